// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, word-size constants
// and the small combinational helpers used by the receiver datapath.
package uart_pkg;

  localparam int unsigned MIN_WORD_BITS = 5;
  localparam int unsigned MAX_WORD_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  // Parity value the transmitter should have sent for the lowest nbits of data.
  function automatic logic expected_parity(input logic [MAX_WORD_BITS-1:0] data,
                                           input logic [3:0]               nbits,
                                           input logic                     sticky,
                                           input logic                     eps);
    logic x;
    x = 1'b0;
    for (int i = 0; i < int'(MAX_WORD_BITS); i++) begin
      if (i < int'(nbits)) begin
        x = x ^ data[i];
      end else begin
        x = x;
      end
    end
    if (sticky) begin
      return ~eps;
    end else if (eps) begin
      return x;
    end else begin
      return ~x;
    end
  endfunction

  // Two-out-of-three majority used for every mid-bit vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Character delivery interface: held character, its status flags, the
// valid/ready handshake and the overrun pulse.
interface uart_rx_os_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid;
  logic                  rx_ready_i;
  logic                  parity_error;
  logic                  frame_error;
  logic                  break_detect;
  logic                  overrun;

  modport master (
    output rx_data_o, rx_valid, parity_error, frame_error, break_detect, overrun,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o, rx_valid, parity_error, frame_error, break_detect, overrun,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle tick every max(baud_div,1) sys_clk
// cycles. A new divisor is only picked up when the counter reloads.
module uart_os_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic [DIV_WIDTH-1:0] reload_s;
  logic                 tick_q;
  logic                 tick_d;

  // Reload value: a divisor of 0 behaves like 1 (tick every cycle).
  always_comb begin
    if (baud_div == DIV_WIDTH'(0)) begin
      reload_s = DIV_WIDTH'(0);
    end else begin
      reload_s = baud_div - DIV_WIDTH'(1);
    end
  end

  // Count down to zero, fire the tick and reload.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == DIV_WIDTH'(0)) begin
      cnt_d  = reload_s;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q - DIV_WIDTH'(1);
      tick_d = 1'b0;
    end
  end

  // Counter and registered tick output.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt_q  <= reload_s;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop input synchroniser, tick-driven frame
// FSM with 3-sample mid-bit voting, and a one-entry valid/ready holding
// register that reports parity/framing/break status with each character.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rxd_i,
  input  logic                 parity_en,
  input  logic                 sticky_parity,
  input  logic                 eps,
  input  logic [1:0]           wls,
  uart_rx_os_if.master         rx_if
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] SC_EARLY = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_MID   = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] SC_LATE  = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(OVERSAMPLE - 1);

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  rxd_s;
  logic                  tick_s;

  rx_state_t             state_q, state_d;
  logic [SC_W-1:0]       sc_q, sc_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            data_q, data_d;
  logic [1:0]            samp_q, samp_d;
  logic                  par_q, par_d;

  logic                  vote_s;
  logic [2:0]            last_bit_s;
  logic                  commit_s;
  logic                  new_pe_s;
  logic                  new_fe_s;
  logic                  new_brk_s;
  logic                  accept_s;

  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  valid_q, valid_d;
  logic                  pe_q, pe_d;
  logic                  fe_q, fe_d;
  logic                  brk_q, brk_d;
  logic                  ovr_q, ovr_d;

  uart_os_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .baud_div (baud_div),
    .tick_o   (tick_s)
  );

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s      = sync2_q;
  assign vote_s     = maj3(samp_q[0], samp_q[1], rxd_s);
  assign last_bit_s = 3'(MIN_WORD_BITS - 1) + {1'b0, wls};

  // Frame FSM next state: samples, votes and commit strobe, all on ticks.
  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    bit_d     = bit_q;
    data_d    = data_q;
    samp_d    = samp_q;
    par_d     = par_q;
    commit_s  = 1'b0;
    new_pe_s  = 1'b0;
    new_fe_s  = 1'b0;
    new_brk_s = 1'b0;
    if (tick_s) begin
      // First two vote samples; the third is the live value at SC_LATE.
      if (sc_q == SC_EARLY) begin
        samp_d[0] = rxd_s;
      end else if (sc_q == SC_MID) begin
        samp_d[1] = rxd_s;
      end else begin
        samp_d = samp_q;
      end
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            sc_d    = SC_W'(0);
            data_d  = 8'h00;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if ((sc_q == SC_LATE) && vote_s) begin
            state_d = IDLE;              // glitch, not a real start bit
          end else if (sc_q == SC_LAST) begin
            state_d = DATA;
            sc_d    = SC_W'(0);
            bit_d   = 3'd0;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        DATA: begin
          if (sc_q == SC_LATE) begin
            data_d[bit_q] = vote_s;
          end else begin
            data_d = data_q;
          end
          if (sc_q == SC_LAST) begin
            sc_d = SC_W'(0);
            if (bit_q == last_bit_s) begin
              state_d = parity_en ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        PARITY: begin
          if (sc_q == SC_LATE) begin
            par_d = vote_s;
          end else begin
            par_d = par_q;
          end
          if (sc_q == SC_LAST) begin
            state_d = STOP;
            sc_d    = SC_W'(0);
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        STOP: begin
          // Commit at mid-stop so back-to-back frames are never missed.
          if (sc_q == SC_LATE) begin
            commit_s  = 1'b1;
            new_pe_s  = parity_en &&
                        (par_q != expected_parity(data_q, 4'(MIN_WORD_BITS) + {2'b00, wls},
                                                  sticky_parity, eps));
            new_fe_s  = ~vote_s;
            new_brk_s = (data_q == 8'h00) && (!parity_en || !par_q) && !vote_s;
            state_d   = vote_s ? IDLE : WAIT_HIGH;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_HIGH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Frame FSM state registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      sc_q    <= SC_W'(0);
      bit_q   <= 3'd0;
      data_q  <= 8'h00;
      samp_q  <= 2'b11;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      samp_q  <= samp_d;
      par_q   <= par_d;
    end
  end

  assign accept_s = valid_q && rx_if.rx_ready_i;

  // Holding register: load on commit if empty or being drained, else drop.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    brk_d   = brk_q;
    ovr_d   = 1'b0;
    if (commit_s) begin
      if (!valid_q || accept_s) begin
        hold_d  = DATA_WIDTH'(data_q);
        valid_d = 1'b1;
        pe_d    = new_pe_s;
        fe_d    = new_fe_s;
        brk_d   = new_brk_s;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register and status outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      hold_q  <= DATA_WIDTH'(0);
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.rx_data_o    = hold_q;
  assign rx_if.rx_valid     = valid_q;
  assign rx_if.parity_error = pe_q;
  assign rx_if.frame_error  = fe_q;
  assign rx_if.break_detect = brk_q;
  assign rx_if.overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are generated at bit level, the
// expected character/status is computed from the frame contents and queued,
// and a monitor pops and compares on every accepted character.
module tb_uart_rx_os;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        rxd_i = 1'b1;
  logic        parity_en = 1'b0;
  logic        sticky_parity = 1'b0;
  logic        eps = 1'b0;
  logic [1:0]  wls = 2'd3;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ovr = 0;
  int   ready_mode = 1;   // 0 = never ready, 1 = always ready, 2 = random

  uart_rx_os_if #(.DATA_WIDTH(8)) rx_if ();

  uart_rx_os #(.OVERSAMPLE(16), .DIV_WIDTH(16), .DATA_WIDTH(8)) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .baud_div      (baud_div),
    .rxd_i         (rxd_i),
    .parity_en     (parity_en),
    .sticky_parity (sticky_parity),
    .eps           (eps),
    .wls           (wls),
    .rx_if         (rx_if)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  function automatic int bit_cycles();
    return ((baud_div == 16'd0) ? 1 : int'(baud_div)) * 16;
  endfunction

  // Parity the transmitter sends, from the line settings and data bit count.
  function automatic logic ref_parity(input logic [7:0] dm);
    int ones;
    ones = $countones(dm);
    if (sticky_parity) return ~eps;
    if (eps) return ones[0];
    return ~ones[0];
  endfunction

  // Send one frame with the current settings; optionally queue its expectation.
  task automatic frame(input logic [7:0] d, input logic pbit, input logic stopb, input bit push);
    int   nb;
    int   bc;
    logic [7:0] dm;
    exp_t e;
    nb = 5 + int'(wls);
    bc = bit_cycles();
    dm = d & 8'((1 << nb) - 1);
    if (push) begin
      e.d   = dm;
      e.pe  = parity_en && (pbit != ref_parity(dm));
      e.fe  = !stopb;
      e.brk = (dm == 8'h00) && (!parity_en || !pbit) && !stopb;
      exp_q.push_back(e);
    end
    rxd_i = 1'b0;
    wait_cyc(bc);
    for (int i = 0; i < nb; i++) begin
      rxd_i = dm[i];
      wait_cyc(bc);
    end
    if (parity_en) begin
      rxd_i = pbit;
      wait_cyc(bc);
    end
    rxd_i = stopb;
    wait_cyc(bc);
    rxd_i = 1'b1;
    wait_cyc(2 * bc);
  endtask

  // Consumer ready driver.
  initial begin
    rx_if.rx_ready_i = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      case (ready_mode)
        0:       rx_if.rx_ready_i = 1'b0;
        1:       rx_if.rx_ready_i = 1'b1;
        default: rx_if.rx_ready_i = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Monitor: count overrun pulses and score every accepted character.
  always @(negedge sys_clk) begin
    if (!reset) begin
      if (rx_if.overrun) n_ovr++;
      if (rx_if.rx_valid && rx_if.rx_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_char: got %0h expected none", rx_if.rx_data_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("char_data_pe_fe_brk",
                {21'd0, rx_if.rx_data_o, rx_if.parity_error, rx_if.frame_error, rx_if.break_detect},
                {21'd0, e});
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       pbit;
    int         t;
    wait_cyc(5);
    check("reset_outputs",
          {22'd0, rx_if.rx_valid, rx_if.rx_data_o, rx_if.parity_error,
           rx_if.frame_error, rx_if.break_detect, rx_if.overrun},
          32'd0);
    reset = 1'b0;
    wait_cyc(100);

    // 8N1 basic character
    wls = 2'd3; parity_en = 1'b0;
    frame(8'hA5, 1'b0, 1'b1, 1'b1);

    // 5-bit even parity: correct then wrong parity bit
    wls = 2'd0; parity_en = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
    frame(8'h15, 1'b1, 1'b1, 1'b1);
    frame(8'h15, 1'b0, 1'b1, 1'b1);

    // False start: 3 ticks low, then a real character
    wls = 2'd3; parity_en = 1'b0;
    rxd_i = 1'b0;
    wait_cyc(12);
    rxd_i = 1'b1;
    wait_cyc(128);
    frame(8'h3C, 1'b0, 1'b1, 1'b1);

    // Break: line low for two frame times
    exp_q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1, brk: 1'b1});
    rxd_i = 1'b0;
    wait_cyc(1280);
    rxd_i = 1'b1;
    wait_cyc(128);
    frame(8'h55, 1'b0, 1'b1, 1'b1);

    // Overrun: consumer stalled across two characters
    ready_mode = 0;
    wait_cyc(2);
    exp_q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0, brk: 1'b0});
    frame(8'h11, 1'b0, 1'b1, 1'b0);
    frame(8'h22, 1'b0, 1'b1, 1'b0);
    check("overrun_held_valid", {31'd0, rx_if.rx_valid}, 32'd1);
    check("overrun_held_data", {24'd0, rx_if.rx_data_o}, 32'h11);
    check("overrun_pulses", n_ovr, 1);
    ready_mode = 1;
    wait_cyc(128);

    // Stop bit forced low with non-zero data
    frame(8'h7E, 1'b0, 1'b0, 1'b1);

    // Reset mid-DATA while a character is held
    ready_mode = 0;
    wait_cyc(2);
    frame(8'h5A, 1'b0, 1'b1, 1'b0);
    rxd_i = 1'b0; wait_cyc(64);
    rxd_i = 1'b1; wait_cyc(64);
    rxd_i = 1'b0; wait_cyc(64);
    reset = 1'b1;
    wait_cyc(1);
    check("midframe_reset_outputs",
          {22'd0, rx_if.rx_valid, rx_if.rx_data_o, rx_if.parity_error,
           rx_if.frame_error, rx_if.break_detect, rx_if.overrun},
          32'd0);
    rxd_i = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    ready_mode = 2;
    wait_cyc(128);
    frame(8'hC3, 1'b0, 1'b1, 1'b1);

    // Randomised frames over word lengths, parity modes and divisors
    for (int n = 0; n < 22; n++) begin
      t = $urandom_range(5);
      baud_div      = (t == 0) ? 16'd0 : (t == 1) ? 16'd1 : (t == 2) ? 16'd2 : 16'd4;
      wls           = 2'($urandom_range(3));
      parity_en     = 1'($urandom_range(1));
      sticky_parity = ($urandom_range(3) == 0);
      eps           = 1'($urandom_range(1));
      d             = 8'($urandom_range(255));
      if ($urandom_range(7) == 0) d = 8'h00;
      pbit          = ref_parity(d & 8'((1 << (5 + int'(wls))) - 1)) ^ ($urandom_range(3) == 0);
      wait_cyc(64);
      frame(d, pbit, ($urandom_range(4) != 0), 1'b1);
    end

    // Drain and final bookkeeping
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) wait_cyc(1);
    check("queue_drained", exp_q.size(), 0);
    check("overrun_total", n_ovr, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
